// File: rtl/bus_slave_mem_pkg.sv
// Shared bus widths, window geometry and FSM encoding for the bus slave memory.
// Imported by bus_slave_mem and bus_regfile.
package bus_slave_mem_pkg;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int WIN_SIZE = 32;
    localparam int IDX_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // The window is aligned, so membership is just a match on the upper address bits.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base);
        return addr[ADDR_W-1:IDX_W] == base[ADDR_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/bus_regfile.sv
// 32 x 8 register file: synchronous write, registered read (write-through on writes), reset-load.
// Output register updates only on i_en; i_clr forces it to zero for out-of-window accesses.
module bus_regfile
    import bus_slave_mem_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_DATA = 8'h00
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic              i_wr,
    input  logic              i_clr,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wr_dat,
    output logic [DATA_W-1:0] o_rd_dat
);

    logic [DATA_W-1:0] r_mem [WIN_SIZE];
    logic [DATA_W-1:0] r_rd_dat;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < WIN_SIZE; i++) begin
                r_mem[i] <= RESET_DATA;
            end
            r_rd_dat <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_rd_dat <= '0;
            end else if (i_wr) begin
                r_mem[i_idx] <= i_wr_dat;
                r_rd_dat     <= i_wr_dat;
            end else begin
                r_rd_dat <= r_mem[i_idx];
            end
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/bus_slave_mem.sv
// Bus slave: level s_sel request, one-cycle s_ack pulse two cycles after s_sel is sampled in IDLE.
// A held request is acknowledged once; s_sel must drop before the next transaction starts.
module bus_slave_mem
    import bus_slave_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 8'h00,
    parameter logic [DATA_W-1:0] RESET_DATA = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_address,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              s_ack,
    output logic              s_err
);

    state_t            r_state;
    state_t            w_next;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_err;
    logic              w_access;
    logic              w_in_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (s_sel) w_next = ST_ACCESS;
            ST_ACCESS:  w_next = ST_ACK;
            ST_ACK:     w_next = s_sel ? ST_RELEASE : ST_IDLE;
            ST_RELEASE: if (!s_sel) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Request fields are captured only when a transaction starts; later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else if (r_state == ST_IDLE && s_sel) begin
            r_wr   <= s_wr;
            r_addr <= s_address;
            r_din  <= s_din;
        end
    end

    assign w_access = (r_state == ST_ACCESS);
    assign w_in_win = in_window(r_addr, BASE_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_access) begin
            r_err <= !w_in_win;
        end
    end

    bus_regfile #(
        .RESET_DATA (RESET_DATA)
    ) u_regfile (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_en     (w_access),
        .i_wr     (r_wr & w_in_win),
        .i_clr    (!w_in_win),
        .i_idx    (r_addr[IDX_W-1:0]),
        .i_wr_dat (r_din),
        .o_rd_dat (s_dout)
    );

    assign s_ack = (r_state == ST_ACK);
    assign s_err = s_ack & r_err;

endmodule
